// File: rtl/vload_pkg.sv
// Shared types and constants for the vector load unit: FSM state encoding,
// default lane geometry and the lane slice helper.
package vload_pkg;

    localparam int VLOAD_LANES  = 8;
    localparam int VLOAD_LANE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } vload_state_t;

    // Bit offset of lane n inside the packed vector.
    function automatic int vload_lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/vload_mem_if.sv
// RAM vector read port seen by the load unit; the unit is the master and
// drives address/enable, the RAM returns mem_q READ_LATENCY clocks later.
interface vload_mem_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int LANE_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_rden;
    logic [LANE_WIDTH-1:0] mem_q;

    modport master (output mem_address, output mem_rden, input mem_q);
    modport slave  (input mem_address, input mem_rden, output mem_q);
endinterface

// File: rtl/vload_return_tracker.sv
// READ_LATENCY-deep shift register of {valid, lane, read} that turns each
// issue slot into the lane capture enable for the matching RAM return.
module vload_return_tracker
    import vload_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int IDX_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [IDX_W-1:0] issue_lane,
    input  logic             issue_read,
    output logic             cap_valid,
    output logic [IDX_W-1:0] cap_lane,
    output logic             cap_read
);

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] read_q, read_d;
    logic [IDX_W-1:0]        lane_q [READ_LATENCY];
    logic [IDX_W-1:0]        lane_d [READ_LATENCY];

    always_comb begin
        vld_d  = '0;
        read_d = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            lane_d[i] = '0;
        end
        vld_d[0]  = issue_valid;
        read_d[0] = issue_read;
        lane_d[0] = issue_lane;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            read_d[i] = read_q[i-1];
            lane_d[i] = lane_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            read_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            read_q <= read_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    assign cap_valid = vld_q[READ_LATENCY-1];
    assign cap_lane  = lane_q[READ_LATENCY-1];
    assign cap_read  = read_q[READ_LATENCY-1];

endmodule

// File: rtl/vector_load_unit.sv
// Reads LANES sequential RAM words from base_address and presents them as one
// vector with a single-cycle valid pulse. Optional lane mask: VLOAD_LANE_MASK_EN.
module vector_load_unit
    import vload_pkg::*;
#(
    parameter int LANES        = VLOAD_LANES,
    parameter int LANE_WIDTH   = VLOAD_LANE_W,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       base_address,
    input  logic [3:0]                  rd_tag,
`ifdef VLOAD_LANE_MASK_EN
    input  logic [LANES-1:0]            lane_mask,
`endif
    vload_mem_if.master                 mem,
    output logic                        busy,
    output logic                        vector_valid,
    output logic [LANES*LANE_WIDTH-1:0] vector_data,
    output logic [3:0]                  vector_rd,
    output vload_state_t                dbg_state
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

    // start is a one-cycle request honoured only in IDLE (dropped while busy);
    // vector_valid is a one-cycle pulse with no back-pressure from the consumer.
    vload_state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0]       base_q, base_d;
    logic [3:0]                  tag_q, tag_d;
    logic [LANES-1:0]            mask_q, mask_d;
    logic [IDX_W-1:0]            issue_cnt_q, issue_cnt_d;
    logic [IDX_W-1:0]            ret_cnt_q, ret_cnt_d;
    logic [LANES*LANE_WIDTH-1:0] lanes_q, lanes_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic                        rden_q, rden_d;
    logic                        busy_q, busy_d;
    logic                        valid_q, valid_d;
    logic [LANES*LANE_WIDTH-1:0] data_q, data_d;
    logic [3:0]                  rd_q, rd_d;
    logic [LANES-1:0]            start_mask;

    logic                        cap_valid;
    logic [IDX_W-1:0]            cap_lane;
    logic                        cap_read;

`ifdef VLOAD_LANE_MASK_EN
    assign start_mask = lane_mask;
`else
    assign start_mask = '1;
`endif

    vload_return_tracker #(
        .READ_LATENCY (READ_LATENCY),
        .IDX_W        (IDX_W)
    ) u_tracker (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (state_q == ISSUE),
        .issue_lane  (issue_cnt_q),
        .issue_read  (rden_q),
        .cap_valid   (cap_valid),
        .cap_lane    (cap_lane),
        .cap_read    (cap_read)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        tag_d       = tag_q;
        mask_d      = mask_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        lanes_d     = lanes_q;
        addr_d      = addr_q;
        rden_d      = 1'b0;
        data_d      = data_q;
        rd_d        = rd_q;

        // Masked slots return no read, so their lane is written with zero.
        if (cap_valid) begin
            ret_cnt_d = ret_cnt_q + 1'b1;
            for (int n = 0; n < LANES; n++) begin
                if (cap_lane == IDX_W'(n)) begin
                    lanes_d[vload_lane_lsb(n, LANE_WIDTH) +: LANE_WIDTH] =
                        cap_read ? mem.mem_q : '0;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ISSUE;
                    base_d      = base_address;
                    tag_d       = rd_tag;
                    mask_d      = start_mask;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    addr_d      = base_address;
                    rden_d      = start_mask[0];
                end
            end
            ISSUE: begin
                if (issue_cnt_q == LAST_LANE) begin
                    state_d = DRAIN;
                end else begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    addr_d      = base_q + ADDR_WIDTH'(issue_cnt_d);
                    rden_d      = mask_q[issue_cnt_d];
                end
            end
            DRAIN: begin
                if (cap_valid && ret_cnt_q == LAST_LANE) begin
                    state_d = DONE;
                    data_d  = lanes_d;
                    rd_d    = tag_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            tag_q       <= '0;
            mask_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            lanes_q     <= '0;
            addr_q      <= '0;
            rden_q      <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            tag_q       <= tag_d;
            mask_q      <= mask_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            lanes_q     <= lanes_d;
            addr_q      <= addr_d;
            rden_q      <= rden_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
        end
    end

    assign mem.mem_address = addr_q;
    assign mem.mem_rden    = rden_q;
    assign busy            = busy_q;
    assign vector_valid    = valid_q;
    assign vector_data     = data_q;
    assign vector_rd       = rd_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_vector_load_unit.sv
// Directed bench for vector_load_unit: one unit at READ_LATENCY=1 and one at
// READ_LATENCY=2, each against a behavioural RAM, with a scoreboard of vectors.
module tb_vector_load_unit;
    import vload_pkg::*;

    localparam int LANES = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs and RAM model ----------------
    logic         start_a, start_b;
    logic [7:0]   base_address;
    logic [3:0]   rd_tag;
    logic [7:0]   mask_b;
    logic         busy_a, busy_b, vector_valid_a, vector_valid_b;
    logic [127:0] vector_data_a, vector_data_b;
    logic [3:0]   vector_rd_a, vector_rd_b;
    vload_state_t dbg_state_a, dbg_state_b;

    logic [15:0]  ram [256];
    logic [15:0]  q_a, s_b, q_b;

    vload_mem_if #(.ADDR_WIDTH(8), .LANE_WIDTH(16)) mif_a ();
    vload_mem_if #(.ADDR_WIDTH(8), .LANE_WIDTH(16)) mif_b ();

    assign mif_a.mem_q = q_a;
    assign mif_b.mem_q = q_b;

    always @(posedge clk) begin
        if (mif_a.mem_rden) q_a <= ram[mif_a.mem_address];
        if (mif_b.mem_rden) s_b <= ram[mif_b.mem_address];
        q_b <= s_b;
    end

    vector_load_unit #(.READ_LATENCY(1)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .start        (start_a),
        .base_address (base_address),
        .rd_tag       (rd_tag),
`ifdef VLOAD_LANE_MASK_EN
        .lane_mask    (8'hFF),
`endif
        .mem          (mif_a),
        .busy         (busy_a),
        .vector_valid (vector_valid_a),
        .vector_data  (vector_data_a),
        .vector_rd    (vector_rd_a),
        .dbg_state    (dbg_state_a)
    );

    vector_load_unit #(.READ_LATENCY(2)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .start        (start_b),
        .base_address (base_address),
        .rd_tag       (rd_tag),
`ifdef VLOAD_LANE_MASK_EN
        .lane_mask    (mask_b),
`endif
        .mem          (mif_b),
        .busy         (busy_b),
        .vector_valid (vector_valid_b),
        .vector_data  (vector_data_b),
        .vector_rd    (vector_rd_b),
        .dbg_state    (dbg_state_b)
    );

    // ---------------- scoreboard ----------------
    int           checks   = 0;
    int           failures = 0;
    logic [131:0] exp_a_q[$];
    logic [131:0] exp_b_q[$];
    int           exp_a_cyc_q[$];
    int           exp_b_cyc_q[$];
    logic [7:0]   addr_log_a[$];
    logic         rden_log_b[$];

    task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_vec(input logic [7:0] base, input logic [7:0] mask);
        logic [127:0] v;
        logic [7:0]   a;
        v = '0;
        for (int n = 0; n < LANES; n++) begin
            a = base + 8'(n);
            if (mask[n]) v[n*16 +: 16] = ram[a];
        end
        return v;
    endfunction

    always @(negedge clk) begin : mon_a
        logic [131:0] e;
        int           c;
        if (!reset && vector_valid_a) begin
            if (exp_a_q.size() == 0) begin
                check("a_unexpected_valid", 132'(vector_valid_a), 132'd0);
            end else begin
                e = exp_a_q.pop_front();
                c = exp_a_cyc_q.pop_front();
                check("a_vector", {vector_rd_a, vector_data_a}, e);
                check("a_latency", 132'(cyc), 132'(c));
            end
        end
        if (!reset && mif_a.mem_rden) addr_log_a.push_back(mif_a.mem_address);
    end

    always @(negedge clk) begin : mon_b
        logic [131:0] e;
        int           c;
        if (!reset && vector_valid_b) begin
            if (exp_b_q.size() == 0) begin
                check("b_unexpected_valid", 132'(vector_valid_b), 132'd0);
            end else begin
                e = exp_b_q.pop_front();
                c = exp_b_cyc_q.pop_front();
                check("b_vector", {vector_rd_b, vector_data_b}, e);
                check("b_latency", 132'(cyc), 132'(c));
            end
        end
        if (!reset && dbg_state_b == ISSUE) rden_log_b.push_back(mif_b.mem_rden);
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; start is sampled at the following posedge (E0).
    task automatic do_start(input bit sel, input logic [7:0] base, input logic [3:0] tag,
                            input bit expect_accept);
        base_address = base;
        rd_tag       = tag;
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        if (expect_accept) begin
            if (sel) begin
                exp_b_q.push_back({tag, model_vec(base, mask_b)});
                exp_b_cyc_q.push_back(cyc + 1 + LANES + 2);
            end else begin
                exp_a_q.push_back({tag, model_vec(base, 8'hFF)});
                exp_a_cyc_q.push_back(cyc + 1 + LANES + 1);
            end
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_valid(input bit sel, input string tag, output int busy_cycles);
        bit seen;
        seen        = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (sel ? vector_valid_b : vector_valid_a) begin
                seen = 1'b1;
            end else begin
                if (sel ? busy_b : busy_a) busy_cycles++;
                @(negedge clk);
            end
        end
        check(tag, 132'(seen), 132'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        int         bc;
        int         hits;
        logic [7:0] ea;

        reset        = 1'b1;
        start_a      = 1'b0;
        start_b      = 1'b0;
        base_address = '0;
        rd_tag       = '0;
`ifdef VLOAD_LANE_MASK_EN
        mask_b = 8'b0000_0101;
`else
        mask_b = 8'hFF;
`endif
        for (int i = 0; i < 256; i++) ram[i] = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 8; i++) ram[8'h10 + i] = 16'h1111 * 16'(i + 1);
        ram[8'hFE] = 16'hAAAA;
        ram[8'hFF] = 16'hBBBB;
        ram[8'h00] = 16'hCCCC;

        idle(3);
        check("rst_busy", 132'(busy_a), 132'd0);
        check("rst_valid", 132'(vector_valid_a), 132'd0);
        check("rst_rden", 132'(mif_a.mem_rden), 132'd0);
        check("rst_addr", 132'(mif_a.mem_address), 132'd0);
        check("rst_data", 132'(vector_data_a), 132'd0);
        check("rst_rd", 132'(vector_rd_a), 132'd0);
        check("rst_state", 132'(dbg_state_a), 132'(IDLE));
        check("rst_busy_b", 132'(busy_b), 132'd0);
        reset = 1'b0;
        idle(2);

        // Basic load from 0x10.
        addr_log_a.delete();
        do_start(1'b0, 8'h10, 4'd5, 1'b1);
        wait_valid(1'b0, "basic_seen", bc);
        check("basic_busy_cycles", 132'(bc), 132'd9);
        check("basic_busy_in_done", 132'(busy_a), 132'd1);
        check("basic_data", 132'(vector_data_a), 132'h8888_7777_6666_5555_4444_3333_2222_1111);
        @(negedge clk);
        check("basic_valid_pulse", 132'(vector_valid_a), 132'd0);
        check("basic_busy_after", 132'(busy_a), 132'd0);
        check("basic_data_hold", 132'(vector_data_a), 132'h8888_7777_6666_5555_4444_3333_2222_1111);
        check("basic_addr_count", 132'(addr_log_a.size()), 132'd8);
        for (int i = 0; i < addr_log_a.size(); i++) begin
            check("basic_addr", 132'(addr_log_a[i]), 132'(8'h10 + 8'(i)));
        end

        // Wrap-around from 0xFE.
        idle(2);
        addr_log_a.delete();
        do_start(1'b0, 8'hFE, 4'd3, 1'b1);
        wait_valid(1'b0, "wrap_seen", bc);
        check("wrap_lanes012", 132'(vector_data_a[47:0]), 132'hCCCC_BBBB_AAAA);
        check("wrap_addr_count", 132'(addr_log_a.size()), 132'd8);
        for (int i = 0; i < addr_log_a.size(); i++) begin
            ea = 8'hFE + 8'(i);
            check("wrap_addr", 132'(addr_log_a[i]), 132'(ea));
        end

        // Start while busy is dropped.
        idle(2);
        addr_log_a.delete();
        do_start(1'b0, 8'h10, 4'd7, 1'b1);
        idle(2);
        do_start(1'b0, 8'h40, 4'd9, 1'b0);
        wait_valid(1'b0, "busy_start_seen", bc);
        idle(15);
        hits = 0;
        foreach (addr_log_a[i]) if (addr_log_a[i][7:4] == 4'h4) hits++;
        check("busy_start_no_4x", 132'(hits), 132'd0);
        check("busy_start_addr_count", 132'(addr_log_a.size()), 132'd8);

        // Back-to-back: second start in the first cycle after DONE.
        do_start(1'b0, 8'h30, 4'd1, 1'b1);
        wait_valid(1'b0, "b2b_first_seen", bc);
        @(negedge clk);
        do_start(1'b0, 8'h50, 4'd2, 1'b1);
        wait_valid(1'b0, "b2b_second_seen", bc);
        check("b2b_second_busy", 132'(bc), 132'd9);

        // Reset mid-load aborts without a valid pulse.
        idle(2);
        do_start(1'b0, 8'h10, 4'd6, 1'b1);
        idle(3);
        reset = 1'b1;
        @(negedge clk);
        void'(exp_a_q.pop_back());
        void'(exp_a_cyc_q.pop_back());
        check("mid_rst_busy", 132'(busy_a), 132'd0);
        check("mid_rst_valid", 132'(vector_valid_a), 132'd0);
        check("mid_rst_rden", 132'(mif_a.mem_rden), 132'd0);
        check("mid_rst_addr", 132'(mif_a.mem_address), 132'd0);
        check("mid_rst_data", 132'(vector_data_a), 132'd0);
        check("mid_rst_rd", 132'(vector_rd_a), 132'd0);
        check("mid_rst_state", 132'(dbg_state_a), 132'(IDLE));
        reset = 1'b0;
        idle(15);
        do_start(1'b0, 8'h10, 4'd6, 1'b1);
        wait_valid(1'b0, "post_rst_seen", bc);

        // READ_LATENCY=2 unit, optionally with a lane mask.
        idle(2);
        rden_log_b.delete();
        do_start(1'b1, 8'h10, 4'hA, 1'b1);
        wait_valid(1'b1, "rl2_seen", bc);
        check("rl2_busy_cycles", 132'(bc), 132'd10);
        check("rl2_slot_count", 132'(rden_log_b.size()), 132'd8);
        for (int i = 0; i < rden_log_b.size(); i++) begin
            check("rl2_rden_slot", 132'(rden_log_b[i]), 132'(mask_b[i]));
        end

        idle(20);
        check("a_queue_drained", 132'(exp_a_q.size()), 132'd0);
        check("b_queue_drained", 132'(exp_b_q.size()), 132'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
